rd_ptr_empty_ctrl: RTL and testbench
====================================

// Module: rd_ptr_empty_ctrl
// PURPOSE
//   Read-domain pointer and status controller for the async FIFO.
//   Consumes the 2-flop-synchronised Gray write pointer and advances the read pointer on accepted reads.
//   Drives the memory read address and the Gray read pointer, which goes to the rd-to-wrt synchroniser.
//   Generates empty, almost-empty, fill level and underflow status, all in the rd_clk domain.
// PARAMETERS
//   ADDR_SIZE          4  FIFO address width; DEPTH = 2**ADDR_SIZE entries; pointers carry ADDR_SIZE+1 bits
//   ALMOST_EMPTY_TH    2  rd_almost_empty asserts when the next fill level is <= this value (0..DEPTH)
// PORTS
//   rd_clk           in   1            read-domain clock; all logic on its rising edge
//   rd_rst           in   1            synchronous, active-high reset
//   rd_en            in   1            read request; accepted only when rd_empty==0
//   sync_wrt_ptr     in   ADDR_SIZE+1  Gray write pointer, already synchronised into rd_clk
//   rd_addr          out  ADDR_SIZE    binary read address to the FIFO memory
//   rd_ptr           out  ADDR_SIZE+1  Gray read pointer, registered; goes to the rd-to-wrt synchroniser
//   rd_empty         out  1            FIFO empty, registered
//   rd_almost_empty  out  1            next fill level <= ALMOST_EMPTY_TH, registered
//   rd_level         out  ADDR_SIZE+1  entries available, 0..DEPTH, registered
//   rd_underflow     out  1            one-cycle pulse when rd_en is high while rd_empty is high
// BEHAVIOUR
//   Reset (rd_rst==1 at an edge): rd_bin=0, rd_ptr=0, rd_empty=1, rd_almost_empty=1, rd_level=0, rd_underflow=0.
//     rd_en is ignored in that cycle. Reset mid-operation discards all state at the next edge; no partial read.
//   rd_inc      = rd_en & ~rd_empty.
//   rd_bin_n    = rd_bin + rd_inc; (ADDR_SIZE+1)-bit, wraps modulo 2**(ADDR_SIZE+1).
//   rd_gray_n   = (rd_bin_n >> 1) ^ rd_bin_n.
//   Every edge:
//     rd_bin <= rd_bin_n; rd_ptr <= rd_gray_n.
//     rd_addr = rd_bin[ADDR_SIZE-1:0], a direct wire from the register with 0-cycle latency.
//   rd_empty <= (rd_gray_n == sync_wrt_ptr).
//     The last read deasserts availability on the same edge: no extra latency, no read past empty.
//   Level:
//     wbin = Gray-to-binary(sync_wrt_ptr).
//     lvl_n = wbin - rd_bin_n, modulo 2**(ADDR_SIZE+1); range 0..DEPTH.
//     rd_level <= lvl_n; rd_almost_empty <= (lvl_n <= ALMOST_EMPTY_TH).
//   rd_underflow <= rd_en & rd_empty. Pointer is unchanged on underflow.
//   Empty is pessimistic: new writes appear no earlier than 2 rd_clk after the write-side update.
//     A transient false empty is legal; a false not-empty is not.
//   Simultaneous read + write arrival in one cycle:
//     level = new wbin - incremented rd_bin; empty follows the comparison above.
//   Wrap: rd_addr goes from DEPTH-1 to 0 and the MSB of rd_bin toggles.
//     The Gray MSB/MSB-1 pattern handles the lap; no special-casing.
//   Every output is driven from a flop except rd_addr, which is a wire from the rd_bin flop.
// STRUCTURE
//   Package fifo_pkg holds:
//     functions bin2gray/gray2bin, parameterised by width;
//     localparam DEPTH = 1<<ADDR_SIZE;
//     a shared pointer-width localparam.
//   One sub-module: gray_to_bin (purely combinational, width ADDR_SIZE+1) for the wbin conversion.
//     The write-side full controller reuses it.
//   Everything else lives inline: pointer register, next-state logic, status flops.
// TESTING  (ADDR_SIZE=4, DEPTH=16, ALMOST_EMPTY_TH=2)
//   1. Reset: rd_rst=1 for 2 edges, rd_en=1
//      -> rd_empty=1, rd_almost_empty=1, rd_ptr=0, rd_addr=0, rd_level=0, rd_underflow=0.
//   2. Fill and drain: sync_wrt_ptr=5'b00010 (3 writes), no reads
//      -> next edge rd_empty=0, rd_level=3, rd_almost_empty=0.
//      Then rd_en=1 for 3 cycles
//      -> rd_addr 0,1,2; rd_ptr 00001,00011,00010; rd_empty=1 at the 3rd edge; rd_level=0.
//   3. Underflow: rd_empty=1, rd_en=1 for 1 cycle
//      -> rd_underflow=1 for exactly 1 cycle; rd_ptr and rd_addr unchanged.
//   4. Wrap: rd_bin=15 (rd_ptr=01000), sync_wrt_ptr=5'b11001 (bin 17), rd_en=1
//      -> rd_addr 15->0; rd_ptr=11000; rd_level=1; rd_almost_empty=1; rd_empty=0.
//   5. Full level: rd_bin=0, sync_wrt_ptr=5'b11000 (bin 16)
//      -> rd_level=16, rd_empty=0, rd_almost_empty=0.
//   6. Reset mid-read: rd_level=5 and rd_en=1 when rd_rst pulses 1 cycle
//      -> next edge all outputs at reset values; rd_level recomputes vs sync_wrt_ptr on the following edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers and sizing constants.
//   FIFO_ADDR_SIZE : default address width for the FIFO slice
//   PTR_W          : pointer width (address plus lap bit)
//   DEPTH          : number of FIFO entries
//   bin2gray/gray2bin : width-independent conversions on zero-extended codes
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_SIZE = 4;
  localparam int unsigned PTR_W          = FIFO_ADDR_SIZE + 1;
  localparam int unsigned DEPTH          = 1 << FIFO_ADDR_SIZE;
  localparam int unsigned CODE_W         = 32;

  // Binary to Gray; callers zero-extend to CODE_W and truncate the result.
  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary by prefix XOR from the MSB down; zero upper bits pass through.
  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b = g;
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_empty_ctrl_if.sv
// Read-side FIFO control bus between the consumer and the read pointer controller.
//   rd_en, sync_wrt_ptr             : consumer request and synchronised Gray write pointer
//   rd_addr, rd_ptr                 : binary memory address and Gray read pointer
//   rd_empty, rd_almost_empty,
//   rd_level, rd_underflow          : read-domain status
interface rd_ptr_empty_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = FIFO_ADDR_SIZE
);

  logic                 rd_en;
  logic [ADDR_SIZE:0]   sync_wrt_ptr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE:0]   rd_ptr;
  logic                 rd_empty;
  logic                 rd_almost_empty;
  logic [ADDR_SIZE:0]   rd_level;
  logic                 rd_underflow;

  // Consumer side: issues reads and supplies the write pointer.
  modport master (
    output rd_en,
    output sync_wrt_ptr,
    input  rd_addr,
    input  rd_ptr,
    input  rd_empty,
    input  rd_almost_empty,
    input  rd_level,
    input  rd_underflow
  );

  // Controller side.
  modport slave (
    input  rd_en,
    input  sync_wrt_ptr,
    output rd_addr,
    output rd_ptr,
    output rd_empty,
    output rd_almost_empty,
    output rd_level,
    output rd_underflow
  );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter, shared by the read and write controllers.
//   gray  : Gray-coded input, W bits
//   bin_c : binary equivalent, W bits (combinational)
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int unsigned W = PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin_c
);

  assign bin_c = W'(gray2bin(CODE_W'(gray)));

endmodule

// File: rtl/rd_ptr_empty_ctrl.sv
// Read-domain pointer and status controller for the async FIFO.
//   rd_clk : read clock, all state on its rising edge
//   rd_rst : synchronous active-high reset
//   bus    : slave side of rd_ptr_empty_ctrl_if (rd_en/sync_wrt_ptr in,
//            rd_addr/rd_ptr/rd_empty/rd_almost_empty/rd_level/rd_underflow out)
module rd_ptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE       = FIFO_ADDR_SIZE,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  rd_ptr_empty_ctrl_if.slave   bus
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  logic [PW-1:0] rd_bin_q;
  logic [PW-1:0] rd_gray_q;
  logic          rd_empty_q;
  logic          rd_almost_empty_q;
  logic [PW-1:0] rd_level_q;
  logic          rd_underflow_q;

  logic          rd_inc;
  logic [PW-1:0] rd_bin_n;
  logic [PW-1:0] rd_gray_n;
  logic [PW-1:0] wbin_c;
  logic [PW-1:0] lvl_n;
  logic          almost_n;

  // Write pointer back to binary for the level subtraction.
  gray_to_bin #(
    .W (PW)
  ) u_wptr_g2b (
    .gray  (bus.sync_wrt_ptr),
    .bin_c (wbin_c)
  );

  // Next pointer and status; a read is accepted only while not empty.
  always_comb begin
    rd_inc    = bus.rd_en & ~rd_empty_q;
    rd_bin_n  = rd_bin_q + PW'(rd_inc);
    rd_gray_n = PW'(bin2gray(CODE_W'(rd_bin_n)));
    lvl_n     = wbin_c - rd_bin_n;
    almost_n  = (CODE_W'(lvl_n) <= ALMOST_EMPTY_TH);
  end

  // Pointer and status registers; empty compares against the next pointer so
  // the final read drops availability on the same edge.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin_q          <= '0;
      rd_gray_q         <= '0;
      rd_empty_q        <= 1'b1;
      rd_almost_empty_q <= 1'b1;
      rd_level_q        <= '0;
      rd_underflow_q    <= 1'b0;
    end else begin
      rd_bin_q          <= rd_bin_n;
      rd_gray_q         <= rd_gray_n;
      rd_empty_q        <= (rd_gray_n == bus.sync_wrt_ptr);
      rd_almost_empty_q <= almost_n;
      rd_level_q        <= lvl_n;
      rd_underflow_q    <= bus.rd_en & rd_empty_q;
    end
  end

  assign bus.rd_addr         = rd_bin_q[ADDR_SIZE-1:0];
  assign bus.rd_ptr          = rd_gray_q;
  assign bus.rd_empty        = rd_empty_q;
  assign bus.rd_almost_empty = rd_almost_empty_q;
  assign bus.rd_level        = rd_level_q;
  assign bus.rd_underflow    = rd_underflow_q;

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Bench for rd_ptr_empty_ctrl: directed scenarios plus randomized traffic
// against a counter-based reference model.
module tb_rd_ptr_empty_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TH = 2;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;

  int total = 0;
  int bad   = 0;

  // Reference model: read count modulo 32 and status derived from counts.
  int m_rd    = 0;
  int m_lvl   = 0;
  bit m_empty = 1'b1;
  bit m_ae    = 1'b1;
  bit m_uf    = 1'b0;

  always #5 rd_clk = ~rd_clk;

  rd_ptr_empty_ctrl_if #(.ADDR_SIZE(AW)) bus ();

  rd_ptr_empty_ctrl #(
    .ADDR_SIZE       (AW),
    .ALMOST_EMPTY_TH (TH)
  ) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus)
  );

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  // Inverse Gray by search over the 32 pointer codes.
  function automatic int bin_of_gray(input int g);
    for (int b = 0; b < 32; b++) begin
      if (gray_of(b) == g) return b;
    end
    return 0;
  endfunction

  // Drive one cycle of inputs (wb = binary write count), advance the model, sample at +1.
  task automatic tick(input bit rst, input bit en, input int wb);
    bit acc;
    rd_rst           = rst;
    bus.rd_en        = en;
    bus.sync_wrt_ptr = PW'(gray_of(wb % 32));
    @(posedge rd_clk);
    if (rst) begin
      m_rd = 0; m_lvl = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    end else begin
      acc     = en && !m_empty;
      m_uf    = en && m_empty;
      m_rd    = (m_rd + int'(acc)) % 32;
      m_lvl   = (bin_of_gray(gray_of(wb % 32)) - m_rd + 32) % 32;
      m_empty = (m_lvl == 0);
      m_ae    = (m_lvl <= int'(TH));
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 0);
    tick(1'b1, 1'b1, 0);
    total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.rd_empty); end
    total++; if (bus.rd_almost_empty !== 1'b1) begin bad++; $display("FAIL reset_almost got=%b exp=1", bus.rd_almost_empty); end
    total++; if (bus.rd_ptr !== 5'd0) begin bad++; $display("FAIL reset_ptr got=%b exp=00000", bus.rd_ptr); end
    total++; if (bus.rd_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.rd_addr); end
    total++; if (bus.rd_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.rd_level); end
    total++; if (bus.rd_underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%b exp=0", bus.rd_underflow); end
  endtask

  task automatic test_fill_drain();
    logic [4:0] exp_ptr [3];
    exp_ptr[0] = 5'b00001; exp_ptr[1] = 5'b00011; exp_ptr[2] = 5'b00010;
    tick(1'b0, 1'b0, 3);
    total++; if (bus.rd_empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", bus.rd_empty); end
    total++; if (bus.rd_level !== 5'd3) begin bad++; $display("FAIL fill_level got=%0d exp=3", bus.rd_level); end
    total++; if (bus.rd_almost_empty !== 1'b0) begin bad++; $display("FAIL fill_almost got=%b exp=0", bus.rd_almost_empty); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.rd_addr !== 4'(i)) begin bad++; $display("FAIL drain_addr%0d got=%0d exp=%0d", i, bus.rd_addr, i); end
      tick(1'b0, 1'b1, 3);
      total++; if (bus.rd_ptr !== exp_ptr[i]) begin bad++; $display("FAIL drain_ptr%0d got=%b exp=%b", i, bus.rd_ptr, exp_ptr[i]); end
    end
    total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", bus.rd_empty); end
    total++; if (bus.rd_level !== 5'd0) begin bad++; $display("FAIL drain_level got=%0d exp=0", bus.rd_level); end
  endtask

  task automatic test_underflow();
    logic [4:0] ptr0;
    logic [3:0] addr0;
    ptr0  = bus.rd_ptr;
    addr0 = bus.rd_addr;
    tick(1'b0, 1'b1, 3);
    total++; if (bus.rd_underflow !== 1'b1) begin bad++; $display("FAIL uf_pulse got=%b exp=1", bus.rd_underflow); end
    total++; if (bus.rd_ptr !== 5'b00010) begin bad++; $display("FAIL uf_ptr got=%b exp=00010 (before %b)", bus.rd_ptr, ptr0); end
    total++; if (bus.rd_addr !== 4'd3) begin bad++; $display("FAIL uf_addr got=%0d exp=3 (before %0d)", bus.rd_addr, addr0); end
    tick(1'b0, 1'b0, 3);
    total++; if (bus.rd_underflow !== 1'b0) begin bad++; $display("FAIL uf_one_cycle got=%b exp=0", bus.rd_underflow); end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 15);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b1, 15);
    total++; if (bus.rd_addr !== 4'd15) begin bad++; $display("FAIL wrap_pre_addr got=%0d exp=15", bus.rd_addr); end
    total++; if (bus.rd_ptr !== 5'b01000) begin bad++; $display("FAIL wrap_pre_ptr got=%b exp=01000", bus.rd_ptr); end
    tick(1'b0, 1'b0, 17);
    tick(1'b0, 1'b1, 17);
    total++; if (bus.rd_addr !== 4'd0) begin bad++; $display("FAIL wrap_addr got=%0d exp=0", bus.rd_addr); end
    total++; if (bus.rd_ptr !== 5'b11000) begin bad++; $display("FAIL wrap_ptr got=%b exp=11000", bus.rd_ptr); end
    total++; if (bus.rd_level !== 5'd1) begin bad++; $display("FAIL wrap_level got=%0d exp=1", bus.rd_level); end
    total++; if (bus.rd_almost_empty !== 1'b1) begin bad++; $display("FAIL wrap_almost got=%b exp=1", bus.rd_almost_empty); end
    total++; if (bus.rd_empty !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b exp=0", bus.rd_empty); end
  endtask

  task automatic test_full_level();
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 16);
    total++; if (bus.rd_level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", bus.rd_level); end
    total++; if (bus.rd_empty !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", bus.rd_empty); end
    total++; if (bus.rd_almost_empty !== 1'b0) begin bad++; $display("FAIL full_almost got=%b exp=0", bus.rd_almost_empty); end
  endtask

  task automatic test_reset_mid_read();
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 5);
    total++; if (bus.rd_level !== 5'd5) begin bad++; $display("FAIL mid_pre_level got=%0d exp=5", bus.rd_level); end
    tick(1'b1, 1'b1, 5);
    total++; if (bus.rd_level !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", bus.rd_level); end
    total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b exp=1", bus.rd_empty); end
    total++; if (bus.rd_ptr !== 5'd0) begin bad++; $display("FAIL mid_ptr got=%b exp=00000", bus.rd_ptr); end
    total++; if (bus.rd_addr !== 4'd0) begin bad++; $display("FAIL mid_addr got=%0d exp=0", bus.rd_addr); end
    total++; if (bus.rd_almost_empty !== 1'b1) begin bad++; $display("FAIL mid_almost got=%b exp=1", bus.rd_almost_empty); end
    tick(1'b0, 1'b0, 5);
    total++; if (bus.rd_level !== 5'd5) begin bad++; $display("FAIL mid_relevel got=%0d exp=5", bus.rd_level); end
    total++; if (bus.rd_empty !== 1'b0) begin bad++; $display("FAIL mid_reempty got=%b exp=0", bus.rd_empty); end
  endtask

  // Random reads/writes; the write count never runs more than DEPTH ahead of the reads.
  task automatic test_random();
    int w;
    int inc;
    w = 0;
    tick(1'b1, 1'b0, 0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        w = 0;
        tick(1'b1, 1'($urandom_range(0, 1)), 0);
      end else begin
        inc = int'($urandom_range(0, 2));
        while (inc > 0 && ((w + inc - m_rd + 64) % 32) > 16) inc--;
        w = (w + inc) % 32;
        tick(1'b0, 1'($urandom_range(0, 1)), w);
      end
      total++; if (bus.rd_addr !== 4'(m_rd % 16)) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", n, bus.rd_addr, m_rd % 16); end
      total++; if (bus.rd_ptr !== 5'(gray_of(m_rd))) begin bad++; $display("FAIL rnd_ptr cyc=%0d got=%b exp=%b", n, bus.rd_ptr, 5'(gray_of(m_rd))); end
      total++; if (bus.rd_level !== 5'(m_lvl)) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", n, bus.rd_level, m_lvl); end
      total++; if (bus.rd_empty !== m_empty) begin bad++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", n, bus.rd_empty, m_empty); end
      total++; if (bus.rd_almost_empty !== m_ae) begin bad++; $display("FAIL rnd_almost cyc=%0d got=%b exp=%b", n, bus.rd_almost_empty, m_ae); end
      total++; if (bus.rd_underflow !== m_uf) begin bad++; $display("FAIL rnd_underflow cyc=%0d got=%b exp=%b", n, bus.rd_underflow, m_uf); end
    end
  endtask

  initial begin
    bus.rd_en        = 1'b0;
    bus.sync_wrt_ptr = '0;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_full_level();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
